// File: rtl/keymgr_input_qualify_pkg.sv
// keymgr_input_qualify_pkg: shared types, check indices and per-stage input requirement mask
package keymgr_input_qualify_pkg;
    typedef enum logic [1:0] {StCreator, StOwnerInt, StOwner, StDisable} keymgr_stage_e;
    localparam int NumInputChk = 6;
    typedef enum logic [2:0] {
        ChkKey, ChkKeyVer, ChkCreatorSeed, ChkOwnerSeed, ChkDevId, ChkHealthState
    } input_chk_idx_e;
    typedef enum logic [1:0] {QualIdle, QualSample, QualDone} qual_state_e;
    // Key and KeyVer are needed by every live stage; Disable needs nothing.
    function automatic logic [NumInputChk-1:0] req_mask(input keymgr_stage_e st);
        logic [NumInputChk-1:0] m;
        m = '0;
        m[ChkKey]         = st != StDisable;
        m[ChkKeyVer]      = st != StDisable;
        m[ChkCreatorSeed] = st == StCreator;
        m[ChkDevId]       = st == StCreator;
        m[ChkHealthState] = st == StCreator;
        m[ChkOwnerSeed]   = st == StOwnerInt;
        return m;
    endfunction
endpackage

// File: rtl/keymgr_input_qualify.sv
// keymgr_input_qualify: samples input valid flags for StableCycles cycles and returns a sticky pass/fail result
// Ports: clk_i/rst_i (sync, active-high); op_req_i/op_ack_o handshake, busy_o in Sample and Done;
// stage_sel_i latched on accept; *_vld_i check flags; inputs_ok_o/err_vec_o registered result;
// op_abort_i exists only when KEYMGR_INPUT_QUALIFY_ABORT_EN is defined.
module keymgr_input_qualify
    import keymgr_input_qualify_pkg::*;
#(
    parameter int StableCycles = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   op_req_i,
    output logic                   op_ack_o,
    output logic                   busy_o,
    input  keymgr_stage_e          stage_sel_i,
    input  logic                   creator_seed_vld_i,
    input  logic                   owner_seed_vld_i,
    input  logic                   devid_vld_i,
    input  logic                   health_state_vld_i,
    input  logic                   key_version_vld_i,
    input  logic                   key_vld_i,
    output logic                   inputs_ok_o,
    output logic [NumInputChk-1:0] err_vec_o
`ifdef KEYMGR_INPUT_QUALIFY_ABORT_EN
    ,
    input  logic                   op_abort_i
`endif
);
    localparam int CntW = $clog2(StableCycles + 1);
    if (StableCycles < 1) begin : g_param_chk
        $error("StableCycles must be >= 1");
    end
    qual_state_e            state_q;
    keymgr_stage_e          stage_q;
    logic [CntW-1:0]        cnt_q;
    logic [NumInputChk-1:0] err_q, err_d, err_vec_q, vld_vec;
    logic                   ok_q, abort;
`ifdef KEYMGR_INPUT_QUALIFY_ABORT_EN
    assign abort = op_abort_i;
`else
    assign abort = 1'b0;
`endif
    assign vld_vec = {health_state_vld_i, devid_vld_i, owner_seed_vld_i,
                      creator_seed_vld_i, key_version_vld_i, key_vld_i};
    assign err_d = err_q | (~vld_vec & req_mask(stage_q));
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= QualIdle;
            stage_q   <= StCreator;
            cnt_q     <= '0;
            err_q     <= '0;
            err_vec_q <= '0;
            ok_q      <= 1'b0;
        end else begin
            case (state_q)
                QualIdle: if (op_req_i) begin
                    stage_q <= stage_sel_i;
                    err_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= QualSample;
                end
                QualSample: if (abort) begin
                    state_q <= QualIdle;
                end else begin
                    err_q <= err_d;
                    cnt_q <= cnt_q + 1'b1;
                    // Result is captured with the last sample so it is valid alongside the ack.
                    if (cnt_q == CntW'(StableCycles - 1)) begin
                        state_q   <= QualDone;
                        ok_q      <= ~|err_d;
                        err_vec_q <= err_d;
                    end
                end
                default: state_q <= QualIdle;
            endcase
        end
    end
    assign op_ack_o    = state_q == QualDone;
    assign busy_o      = state_q != QualIdle;
    assign inputs_ok_o = ok_q;
    assign err_vec_o   = err_vec_q;
endmodule

// File: tb/tb_keymgr_input_qualify.sv
// tb_keymgr_input_qualify: randomized self-checking bench against a per-stage requirement model
module tb_keymgr_input_qualify;
    import keymgr_input_qualify_pkg::*;
    localparam int S = 4;
    logic          clk = 0, rst = 1, req = 0, abort = 0;
    logic          ack, busy, ok;
    logic [5:0]    err, flags = '1;
    keymgr_stage_e stage_sel = StCreator;
    int            n_chk = 0, n_pass = 0;

    keymgr_input_qualify #(.StableCycles(S)) dut (
        .clk_i(clk), .rst_i(rst), .op_req_i(req), .op_ack_o(ack), .busy_o(busy),
        .stage_sel_i(stage_sel),
        .creator_seed_vld_i(flags[2]), .owner_seed_vld_i(flags[3]), .devid_vld_i(flags[4]),
        .health_state_vld_i(flags[5]), .key_version_vld_i(flags[1]), .key_vld_i(flags[0]),
        .inputs_ok_o(ok), .err_vec_o(err)
`ifdef KEYMGR_INPUT_QUALIFY_ABORT_EN
        , .op_abort_i(abort)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Required checks per stage, bit order Key, KeyVer, CreatorSeed, OwnerSeed, DevId, HealthState.
    function automatic logic [5:0] model_mask(input keymgr_stage_e st);
        case (st)
            StCreator:  return 6'b110111;
            StOwnerInt: return 6'b001011;
            StOwner:    return 6'b000011;
            default:    return 6'b000000;
        endcase
    endfunction

    task automatic run_op(input keymgr_stage_e st, input logic [5:0] base, input int gc,
                          input logic [5:0] gm, input bit rnd, input bit done_req, input string nm);
        logic [5:0] exp_err, f;
        exp_err = '0;
        stage_sel = st;
        req = 1;
        flags = '0;
        step();
        req = 0;
        for (int i = 0; i < S; i++) begin
            n_chk++;
            if ({ack, busy} !== 2'b01) $display("FAIL %s sample%0d ack/busy=%b want 01", nm, i, {ack, busy});
            else n_pass++;
            f = rnd ? 6'($urandom | $urandom) : ((i == gc) ? (base & ~gm) : base);
            flags = f;
            stage_sel = keymgr_stage_e'($urandom_range(0, 3));
            if (rnd) req = 1'($urandom_range(0, 1));
            exp_err |= ~f & model_mask(st);
            step();
        end
        req = done_req;
        n_chk++;
        if ({ack, busy, ok, err} !== {2'b11, exp_err == 6'd0, exp_err})
            $display("FAIL %s done ack/busy/ok/err=%b want %b", nm, {ack, busy, ok, err},
                     {2'b11, exp_err == 6'd0, exp_err});
        else n_pass++;
        step();
        req = 0;
        n_chk++;
        if ({ack, busy} !== 2'b00) $display("FAIL %s after_done ack/busy=%b want 00", nm, {ack, busy});
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        step();
        n_chk++;
        if ({ack, busy, ok, err} !== 9'd0) $display("FAIL reset outputs=%b want 0", {ack, busy, ok, err});
        else n_pass++;
        rst = 0;
        step();
        n_chk++;
        if ({ack, busy} !== 2'b00) $display("FAIL reset_idle ack/busy=%b want 00", {ack, busy});
        else n_pass++;
    endtask

    task automatic test_basic();
        run_op(StCreator, 6'b111111, -1, 6'b0, 0, 0, "all_ok");
        run_op(StCreator, 6'b111111, 2, 6'b010000, 0, 0, "devid_glitch");
        run_op(StOwner, 6'b110011, -1, 6'b0, 0, 0, "owner_masked");
        run_op(StDisable, 6'b000000, -1, 6'b0, 0, 0, "disable_all_bad");
        run_op(StCreator, 6'b111111, S - 1, 6'b100000, 0, 0, "health_last_cycle");
    endtask

    task automatic test_req_in_done();
        run_op(StOwnerInt, 6'b111101, -1, 6'b0, 0, 1, "keyver_done_req");
        step();
        n_chk++;
        if ({ack, busy, ok, err} !== {3'b000, 6'b000010})
            $display("FAIL dropped_req state=%b want 000000010", {ack, busy, ok, err});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        stage_sel = StCreator;
        flags = '1;
        req = 1;
        step();
        req = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        n_chk++;
        if ({ack, busy, ok, err} !== 9'd0) $display("FAIL reset_mid outputs=%b want 0", {ack, busy, ok, err});
        else n_pass++;
        step();
        n_chk++;
        if ({ack, busy} !== 2'b00) $display("FAIL reset_mid_noack ack/busy=%b want 00", {ack, busy});
        else n_pass++;
        run_op(StCreator, 6'b111111, -1, 6'b0, 0, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            run_op(keymgr_stage_e'($urandom_range(0, 3)), 6'b0, -1, 6'b0, 1, 1'($urandom_range(0, 1)), "random");
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

`ifdef KEYMGR_INPUT_QUALIFY_ABORT_EN
    task automatic test_abort();
        run_op(StCreator, 6'b111110, -1, 6'b0, 0, 0, "pre_abort");
        stage_sel = StCreator;
        flags = '0;
        req = 1;
        step();
        req = 0;
        step();
        abort = 1;
        step();
        abort = 0;
        n_chk++;
        if ({ack, busy, ok, err} !== {3'b000, 6'b000001})
            $display("FAIL abort_mid state=%b want 000000001", {ack, busy, ok, err});
        else n_pass++;
        req = 1;
        step();
        req = 0;
        repeat (S - 1) step();
        abort = 1;
        step();
        abort = 0;
        n_chk++;
        if ({ack, busy, ok, err} !== {3'b000, 6'b000001})
            $display("FAIL abort_terminal state=%b want 000000001", {ack, busy, ok, err});
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_req_in_done();
        test_reset_mid();
        test_random();
`ifdef KEYMGR_INPUT_QUALIFY_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
